// File: rtl/led_driver.sv
// LED output stage: turns the latched led register value into board pin levels,
// with global PWM dimming and optional blinking set through a config write port.
module led_driver #(
    parameter int unsigned NUM_LEDS    = 6,
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned BLINK_TICKS = 13500000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic                cfg_write_enable,
    input  logic [31:0]         cfg_data_in,
    output logic [NUM_LEDS-1:0] led_pins,
    output logic                pwm_wrap
);

    localparam int unsigned         BLINK_W    = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
    localparam logic [NUM_LEDS-1:0] PIN_INVERT = {NUM_LEDS{ACTIVE_LOW}};

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_reg;
    logic [PWM_BITS-1:0] duty_shadow;
    logic                blink_en;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    logic                pwm_on;
    logic [NUM_LEDS-1:0] lit;

    // Config bits above the blink enable carry no meaning for this block.
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^cfg_data_in[31:9];

    // Full-scale and zero duty are special-cased so 0xFF is truly always on.
    always_comb begin
        pwm_on = 1'b0;
        if (duty_shadow == PWM_MAX) begin
            pwm_on = 1'b1;
        end else if (duty_shadow != '0) begin
            pwm_on = (pwm_cnt < duty_shadow);
        end
        lit = led_in & {NUM_LEDS{pwm_on & blink_phase}};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt     <= '0;
            pwm_wrap    <= 1'b0;
            duty_reg    <= '1;
            duty_shadow <= '1;
            blink_en    <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            led_pins    <= PIN_INVERT;
        end else begin
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            pwm_wrap <= (pwm_cnt == PWM_MAX);
            // Duty only changes at a period boundary to avoid glitching a period.
            if (pwm_cnt == PWM_MAX) begin
                duty_shadow <= duty_reg;
            end

            if (cfg_write_enable) begin
                duty_reg <= cfg_data_in[PWM_BITS-1:0];
                blink_en <= cfg_data_in[8];
            end

            // While disabled the counter is parked so enabling starts in the on phase.
            if (!blink_en) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end

            led_pins <= lit ^ PIN_INVERT;
        end
    end

endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver: reset, PWM duty cases, wrap-boundary config
// timing and blinking, with BLINK_TICKS shortened to 8.
module tb_led_driver;

    logic       clk;
    logic       rst_n;
    logic [5:0] led_in;
    logic       cfg_write_enable;
    logic [31:0] cfg_data_in;
    logic [5:0] led_pins;
    logic       pwm_wrap;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int on_cnt;

    led_driver #(
        .NUM_LEDS   (6),
        .PWM_BITS   (8),
        .BLINK_TICKS(8),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .led_in          (led_in),
        .cfg_write_enable(cfg_write_enable),
        .cfg_data_in     (cfg_data_in),
        .led_pins        (led_pins),
        .pwm_wrap        (pwm_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench right after the last reset edge, where pwm_cnt is 0.
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic cfg_write(input logic [31:0] data);
        cfg_write_enable = 1'b1;
        cfg_data_in      = data;
        tick();
        cfg_write_enable = 1'b0;
        cfg_data_in      = '0;
    endtask

    initial begin
        rst_n            = 1'b0;
        led_in           = 6'b101010;
        cfg_write_enable = 1'b1;
        cfg_data_in      = 32'h0000_0100;   // write colliding with reset must be lost
        tick();
        tick();
        check("reset_pins", 32'(led_pins), 32'h3F);
        check("reset_wrap", 32'(pwm_wrap), 32'h0);
        tick();
        cfg_write_enable = 1'b0;
        cfg_data_in      = '0;
        rst_n            = 1'b1;
        cyc              = 0;
        tick();
        check("post_reset_pins", 32'(led_pins), 32'b010101);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("reset_beats_cfg", 32'(led_pins), 32'b010101);
        end

        // Default config: full duty, no blink, wrap every 256 cycles.
        led_in = 6'b000001;
        do_reset();
        for (int i = 0; i < 512; i++) begin
            tick();
            check("default_pins", 32'(led_pins), 32'b111110);
            check("default_wrap", 32'(pwm_wrap), (cyc % 256 == 0) ? 32'h1 : 32'h0);
        end

        // Duty 0x80 takes effect at the wrap at cycle 768.
        led_in = 6'b001010;
        cfg_write(32'h0000_0080);
        while (cyc < 768) tick();
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            check("duty80_pins", 32'(led_pins),
                  (((cyc - 1) % 256) < 128) ? 32'b110101 : 32'b111111);
            if (led_pins == 6'b110101) on_cnt++;
        end
        check("duty80_on_count", 32'(on_cnt), 32'd128);

        // Duty 0: dark from the wrap at cycle 1280 onward.
        cfg_write(32'h0000_0000);
        while (cyc < 1280) tick();
        check("wrap_1280", 32'(pwm_wrap), 32'h1);
        for (int i = 0; i < 256; i++) begin
            tick();
            check("duty0_pins", 32'(led_pins), 32'h3F);
        end

        // Back to 0xFF, then write 0x40 in the cycle pwm_cnt is 255.
        cfg_write(32'h0000_00FF);
        while (cyc < 2047) tick();
        cfg_write(32'h0000_0040);
        check("wrap_2048", 32'(pwm_wrap), 32'h1);
        for (int i = 0; i < 256; i++) begin
            tick();
            check("old_duty_period", 32'(led_pins), 32'b110101);
        end
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            check("duty40_pins", 32'(led_pins),
                  (((cyc - 1) % 256) < 64) ? 32'b110101 : 32'b111111);
            if (led_pins == 6'b110101) on_cnt++;
        end
        check("duty40_on_count", 32'(on_cnt), 32'd64);

        // Blink: enable at edge 1, re-write enable at edge 5 must not restart.
        led_in = 6'b000011;
        do_reset();
        cfg_write(32'h0000_01FF);
        for (int i = 0; i < 42; i++) begin
            if (cyc == 4) begin
                cfg_write_enable = 1'b1;
                cfg_data_in      = 32'h0000_01FF;
            end else begin
                cfg_write_enable = 1'b0;
                cfg_data_in      = '0;
            end
            tick();
            check("blink_pins", 32'(led_pins),
                  ((((cyc - 2) / 8) % 2) == 0) ? 32'b111100 : 32'b111111);
        end
        cfg_write(32'h0000_00FF);   // disable mid off-phase at edge 44
        check("blink_off_44", 32'(led_pins), 32'b111111);
        tick();
        check("blink_off_45", 32'(led_pins), 32'b111111);
        tick();
        check("blink_stop_46", 32'(led_pins), 32'b111100);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("blink_stopped", 32'(led_pins), 32'b111100);
        end

        // Reset in the middle of an off phase.
        cfg_write(32'h0000_01FF);
        for (int i = 0; i < 12; i++) tick();
        check("blink_mid_off", 32'(led_pins), 32'b111111);
        rst_n = 1'b0;
        tick();
        check("blink_reset_pins", 32'(led_pins), 32'h3F);
        check("blink_reset_wrap", 32'(pwm_wrap), 32'h0);
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("after_reset_no_blink", 32'(led_pins), 32'b111100);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
